// File: rtl/mult_acc_pkg.sv
// Shared types and widths for the frame multiply-accumulate stage.
package mult_acc_pkg;

    localparam int unsigned PROD_W = 4;
    localparam int unsigned OP_W   = 2;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

endpackage

// File: rtl/mult_accumulator_if.sv
// Operand stream in, frame result out; master is the upstream/consumer side.
interface mult_accumulator_if #(
    parameter int unsigned ACC_W   = 16,
    parameter int unsigned COUNT_W = 4
);
    import mult_acc_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [OP_W-1:0]    in_a;
    logic [OP_W-1:0]    in_b;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_sum;
    logic [COUNT_W-1:0] out_count;
    logic               out_overflow;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_overflow
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_overflow
    );

endinterface

// File: rtl/two_bit_multiplier.sv
// Unsigned 2x2-bit multiplier, purely combinational.
module two_bit_multiplier
    import mult_acc_pkg::*;
(
    input  logic [OP_W-1:0]   a_i,
    input  logic [OP_W-1:0]   b_i,
    output logic [PROD_W-1:0] prod_o
);

    assign prod_o = PROD_W'(a_i) * PROD_W'(b_i);

endmodule

// File: rtl/mult_accumulator.sv
// Frame multiply-accumulate: sums a*b over beats up to in_last (or a full
// counter), then holds sum/count/overflow on the output until taken.
module mult_accumulator
    import mult_acc_pkg::*;
#(
    parameter int unsigned ACC_W   = 16,
    parameter int unsigned COUNT_W = 4
) (
    input logic              clk,
    input logic              rst_n,
    mult_accumulator_if.slave bus
);

    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic               beat;
    logic               close;
    logic [OP_W-1:0]    op_a;
    logic [OP_W-1:0]    op_b;
    logic [PROD_W-1:0]  prod;
    logic [ACC_W:0]     sum;
    logic [COUNT_W-1:0] count_inc;

    assign beat = bus.in_valid & in_ready_q;

    // Operands are gated by the handshake so unqualified X never reaches state.
    assign op_a = beat ? bus.in_a : '0;
    assign op_b = beat ? bus.in_b : '0;

    two_bit_multiplier u_mult (
        .a_i    (op_a),
        .b_i    (op_b),
        .prod_o (prod)
    );

    assign sum       = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};
    assign count_inc = count_q + COUNT_W'(1);
    // A full beat counter closes the frame even without in_last.
    assign close     = (beat & bus.in_last) | (count_inc == COUNT_MAX);

    // Next-state, accumulator and handshake decode.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (beat) begin
                    acc_d   = ACC_W'(prod);
                    count_d = count_inc;
                    ovf_d   = 1'b0;
                    state_d = close ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (beat) begin
                    acc_d   = sum[ACC_W-1:0];
                    count_d = count_inc;
                    ovf_d   = ovf_q | sum[ACC_W];
                    if (close) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Handshake flags are registered and decoded from the next state only.
        in_ready_d  = (state_d != DONE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_sum      = acc_q;
    assign bus.out_count    = count_q;
    assign bus.out_overflow = ovf_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// Drives three configurations (16/4, 5/4, 16/2) with one shared stream and
// compares each against a frame-level arithmetic model.
module tb_mult_accumulator;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] in_a;
    logic [1:0] in_b;
    logic       in_last;
    logic       out_ready;

    int n_checks;
    int n_errors;

    mult_accumulator_if #(.ACC_W(16), .COUNT_W(4)) if0 ();
    mult_accumulator_if #(.ACC_W(5),  .COUNT_W(4)) if1 ();
    mult_accumulator_if #(.ACC_W(16), .COUNT_W(2)) if2 ();

    mult_accumulator #(.ACC_W(16), .COUNT_W(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    mult_accumulator #(.ACC_W(5),  .COUNT_W(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    mult_accumulator #(.ACC_W(16), .COUNT_W(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;  assign if2.in_valid = in_valid;
    assign if0.in_a = in_a;          assign if1.in_a = in_a;          assign if2.in_a = in_a;
    assign if0.in_b = in_b;          assign if1.in_b = in_b;          assign if2.in_b = in_b;
    assign if0.in_last = in_last;    assign if1.in_last = in_last;    assign if2.in_last = in_last;
    assign if0.out_ready = out_ready; assign if1.out_ready = out_ready; assign if2.out_ready = out_ready;

    logic [31:0] o_ready[3];
    logic [31:0] o_valid[3];
    logic [31:0] o_sum[3];
    logic [31:0] o_cnt[3];
    logic [31:0] o_ovf[3];

    assign o_ready[0] = 32'(if0.in_ready);     assign o_ready[1] = 32'(if1.in_ready);
    assign o_ready[2] = 32'(if2.in_ready);
    assign o_valid[0] = 32'(if0.out_valid);    assign o_valid[1] = 32'(if1.out_valid);
    assign o_valid[2] = 32'(if2.out_valid);
    assign o_sum[0]   = 32'(if0.out_sum);      assign o_sum[1]   = 32'(if1.out_sum);
    assign o_sum[2]   = 32'(if2.out_sum);
    assign o_cnt[0]   = 32'(if0.out_count);    assign o_cnt[1]   = 32'(if1.out_count);
    assign o_cnt[2]   = 32'(if2.out_count);
    assign o_ovf[0]   = 32'(if0.out_overflow); assign o_ovf[1]   = 32'(if1.out_overflow);
    assign o_ovf[2]   = 32'(if2.out_overflow);

    // Reference model: per-configuration frame total, beat count and busy flag.
    int acc_w[3]  = '{16, 5, 16};
    int beat_max[3] = '{15, 15, 3};
    int total[3];
    int nbeat[3];
    bit busy[3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            total[i] = 0;
            nbeat[i] = 0;
            busy[i]  = 1'b0;
        end
    endtask

    task automatic model_check();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d_in_ready", i), o_ready[i], 32'(!busy[i]));
            chk($sformatf("d%0d_out_valid", i), o_valid[i], 32'(busy[i]));
            if (busy[i]) begin
                chk($sformatf("d%0d_sum", i), o_sum[i], 32'(total[i] % (1 << acc_w[i])));
                chk($sformatf("d%0d_count", i), o_cnt[i], 32'(nbeat[i]));
                chk($sformatf("d%0d_ovf", i), o_ovf[i], 32'(total[i] >= (1 << acc_w[i])));
            end
        end
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge.
    task automatic step();
        @(negedge clk);
        model_check();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (busy[i]) begin
                if (out_ready) begin
                    busy[i]  = 1'b0;
                    total[i] = 0;
                    nbeat[i] = 0;
                end
            end else if (in_valid) begin
                total[i] += int'(in_a) * int'(in_b);
                nbeat[i]++;
                if (in_last || nbeat[i] == beat_max[i]) busy[i] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic beat(input int a, input int b, input bit last);
        in_valid = 1'b1;
        in_a     = 2'(a);
        in_b     = 2'(b);
        in_last  = last;
        step();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) step();
    endtask

    // Asynchronous reset asserted between edges; outputs must clear without a clock.
    task automatic rst_pulse();
        rst_n = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("d%0d_rst_in_ready", i), o_ready[i], 32'd1);
            chk($sformatf("d%0d_rst_out_valid", i), o_valid[i], 32'd0);
            chk($sformatf("d%0d_rst_sum", i), o_sum[i], 32'd0);
            chk($sformatf("d%0d_rst_count", i), o_cnt[i], 32'd0);
            chk($sformatf("d%0d_rst_ovf", i), o_ovf[i], 32'd0);
        end
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_pulse();

        // Idle: nothing comes out without input.
        idle(10);

        // Single-beat frame.
        beat(3, 2, 1'b1);
        chk("single_valid", o_valid[0], 32'd1);
        chk("single_sum", o_sum[0], 32'd6);
        chk("single_count", o_cnt[0], 32'd1);
        chk("single_ovf", o_ovf[0], 32'd0);
        idle(2);
        chk("single_back_idle", o_ready[0], 32'd1);

        // Multi-beat frame held under backpressure.
        out_ready = 1'b0;
        beat(1, 1, 1'b0);
        beat(2, 3, 1'b0);
        beat(3, 3, 1'b1);
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_sum", o_sum[0], 32'd16);
            chk("bp_count", o_cnt[0], 32'd3);
            chk("bp_in_ready", o_ready[0], 32'd0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_released_ready", o_ready[0], 32'd1);
        chk("bp_released_valid", o_valid[0], 32'd0);
        idle(2);

        // Wrap and overflow on the 5-bit accumulator.
        out_ready = 1'b0;
        beat(3, 3, 1'b0);
        beat(3, 3, 1'b0);
        beat(3, 3, 1'b0);
        beat(3, 3, 1'b1);
        chk("wrap_sum", o_sum[1], 32'd4);
        chk("wrap_count", o_cnt[1], 32'd4);
        chk("wrap_ovf", o_ovf[1], 32'd1);
        out_ready = 1'b1;
        idle(1);
        beat(1, 1, 1'b1);
        chk("wrap_next_ovf", o_ovf[1], 32'd0);
        chk("wrap_next_sum", o_sum[1], 32'd1);
        idle(2);

        // Forced close on the 2-bit beat counter.
        out_ready = 1'b0;
        beat(1, 2, 1'b0);
        beat(1, 2, 1'b0);
        beat(1, 2, 1'b0);
        chk("force_valid", o_valid[2], 32'd1);
        chk("force_count", o_cnt[2], 32'd3);
        chk("force_sum", o_sum[2], 32'd6);
        out_ready = 1'b1;
        idle(1);
        beat(1, 2, 1'b1);
        chk("force_new_count", o_cnt[2], 32'd1);
        chk("force_new_sum", o_sum[2], 32'd2);
        chk("force_wide_count", o_cnt[0], 32'd4);
        chk("force_wide_sum", o_sum[0], 32'd8);
        idle(2);

        // Reset mid-frame discards the partial frame.
        beat(1, 1, 1'b0);
        beat(2, 1, 1'b0);
        in_valid = 1'b0;
        rst_pulse();
        idle(3);
        beat(2, 2, 1'b1);
        chk("rst_frame_sum", o_sum[0], 32'd4);
        chk("rst_frame_count", o_cnt[0], 32'd1);
        idle(2);

        // Random traffic with random backpressure.
        for (int k = 0; k < 600; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = 2'($urandom_range(0, 3));
            in_b      = 2'($urandom_range(0, 3));
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            step();
            if (k == 300) rst_pulse();
        end

        out_ready = 1'b1;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mult_accumulator.md
Name: mult_accumulator

Overview:
Frame-based multiply-accumulate stage that sits directly downstream of two_bit_multiplier and consumes its product.
- Accepts a valid/ready stream of 2-bit operand pairs and forms each product through an embedded two_bit_multiplier.
- Sums the products over a frame delimited by in_last.
- Presents the frame sum, beat count and overflow flag on a valid/ready output port.

Parameters:
ACC_W, 16, accumulator and out_sum width in bits; legal range 4 to 32.
COUNT_W, 4, beat counter width; a frame holds at most 2^COUNT_W-1 beats.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand beat valid.
in_ready  output  1  block can accept a beat.
in_a  input  2  multiplicand, unsigned.
in_b  input  2  multiplier, unsigned.
in_last  input  1  final beat of the frame; qualified by in_valid.
out_valid  output  1  frame result valid.
out_ready  input  1  consumer accepts the result.
out_sum  output  ACC_W  frame sum of products, modulo 2^ACC_W.
out_count  output  COUNT_W  number of beats in the frame.
out_overflow  output  1  at least one carry out of ACC_W occurred during the frame.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, acc=0, count=0, ovf=0, out_valid=0, in_ready=1 (registered), out_sum=0, out_count=0, out_overflow=0.
- Reset mid-frame or mid-output: all state clears immediately and the partial frame is discarded. No output is produced for it.
- Beat transfer: occurs on a rising edge when in_valid && in_ready.
- Output transfer: occurs on a rising edge when out_valid && out_ready.
- Product: prod = in_a*in_b, 4 bits unsigned, range 0..9, zero-extended to ACC_W+1.
  - Sum formed as acc + prod.
  - acc takes the low ACC_W bits of the sum.
  - ovf |= bit ACC_W of the sum.
- States:
  - IDLE: in_ready=1, out_valid=0, acc=0, count=0.
    - On a beat: acc=prod, count=1, ovf=0.
    - If in_last, go to DONE; else go to ACCUM.
  - ACCUM: in_ready=1.
    - On a beat: accumulate and increment count.
    - Go to DONE if in_last, or if count reaches 2^COUNT_W-1 (forced frame close).
    - With no beat, hold.
  - DONE: in_ready=0, out_valid=1.
    - out_sum, out_count and out_overflow are driven from registers and stay stable until the transfer.
    - On an output transfer: clear acc, count and ovf; go to IDLE.
- Latency: for a last beat accepted at edge k, out_valid=1 in the cycle after edge k. There is no combinational in-to-out path.
- Combinational paths: out_ready does not combinationally affect in_ready. in_ready depends only on state.
- Idle throughput: one beat per cycle. A frame of N beats occupies N+1 cycles minimum, plus any out_ready stall.
- in_last while in_valid=0 is ignored.
- A beat with in_valid held while in_ready=0 is not consumed. The upstream must hold it stable until accepted.
- Unknown values: inputs sampled only when qualified; X on unqualified inputs must not propagate to state.

Decomposition:
- Package mult_acc_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t
  - localparam PROD_W=4
  - localparam OP_W=2
- One sub-module: instance of the existing two_bit_multiplier for the product. No other hierarchy.

Test Plan:
- Reset/idle: assert rst_n=0 mid-cycle -> all outputs immediately at reset values and in_ready=1; release rst_n, hold in_valid=0 for 10 cycles -> out_valid stays 0.
- Single-beat frame: a=3, b=2, last=1, out_ready=1 -> next cycle out_valid=1, out_sum=6, out_count=1, out_overflow=0; IDLE after transfer.
- Multi-beat with backpressure: beats (1,1),(2,3),(3,3) with last on the third; out_ready=0 for 5 cycles -> out_sum=16 and out_count=3 held stable, in_ready=0 throughout; then out_ready=1 -> single transfer, in_ready=1 next cycle.
- Overflow/wrap with ACC_W=5: four beats (3,3), last on the fourth -> out_sum=4 (36 mod 32), out_count=4, out_overflow=1; next frame (1,1) last -> out_overflow=0.
- Forced close with COUNT_W=2: beats (1,2),(1,2),(1,2) with no in_last -> DONE after the third beat, out_count=3, out_sum=6; a fourth beat starts a new frame.
- Reset mid-frame: two beats accepted, then rst_n pulse -> no output; a new frame (2,2) last -> out_sum=4, out_count=1.
